// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// Multiply is shift-add and divide is restoring division, both on operand
// magnitudes at one bit per cycle. A final FIX cycle applies sign
// correction and commits the result to HI/LO. MTHI/MTLO writes are
// honoured only while no operation is in flight.
module mul_div_unit #(
  parameter int DATA_W  = 32,
  parameter bit SIGN_EN = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [1:0]        op_i,
  input  logic [DATA_W-1:0] src1_i,
  input  logic [DATA_W-1:0] src2_i,
  input  logic              hi_we_i,
  input  logic              lo_we_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              div_zero_o,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state_reg, state_next;

  logic [CNT_W-1:0]  cnt_reg;
  logic [DATA_W-1:0] a_reg;        // multiplicand or divisor magnitude
  logic [DATA_W-1:0] hi_acc_reg;   // product high half / partial remainder
  logic [DATA_W-1:0] lo_acc_reg;   // multiplier bits / dividend bits -> quotient
  logic              op_div_reg;
  logic              neg_res_reg;  // operand signs differ
  logic              neg_rem_reg;  // dividend was negative
  logic              dz_reg;       // last accepted op was a divide by zero
  logic [DATA_W-1:0] hi_reg, lo_reg;

  // Start decode: operands are reduced to magnitudes at acceptance time
  logic              idle_or_done;
  logic              accept;
  logic              op_signed;
  logic              s1_neg, s2_neg;
  logic [DATA_W-1:0] mag1, mag2;
  logic              div_zero_start;

  assign idle_or_done   = (state_reg == IDLE) || (state_reg == DONE);
  assign accept         = start_i && idle_or_done;
  assign op_signed      = SIGN_EN && !op_i[0];
  assign s1_neg         = op_signed && src1_i[DATA_W-1];
  assign s2_neg         = op_signed && src2_i[DATA_W-1];
  assign mag1           = s1_neg ? -src1_i : src1_i;
  assign mag2           = s2_neg ? -src2_i : src2_i;
  assign div_zero_start = op_i[1] && (src2_i == '0);

  // Per-iteration datapath for both algorithms
  logic [DATA_W:0]     mul_sum;
  logic [DATA_W:0]     div_shift;
  logic [DATA_W:0]     div_diff;
  logic [2*DATA_W-1:0] prod_fix;
  logic [DATA_W-1:0]   quo_fix, rem_fix;

  assign mul_sum   = {1'b0, hi_acc_reg} + (lo_acc_reg[0] ? {1'b0, a_reg} : '0);
  assign div_shift = {hi_acc_reg, lo_acc_reg[DATA_W-1]};
  // A set top bit means the trial subtraction borrowed: restore instead
  assign div_diff  = div_shift - {1'b0, a_reg};
  assign prod_fix  = neg_res_reg ? -{hi_acc_reg, lo_acc_reg} : {hi_acc_reg, lo_acc_reg};
  assign quo_fix   = neg_res_reg ? -lo_acc_reg : lo_acc_reg;
  assign rem_fix   = neg_rem_reg ? -hi_acc_reg : hi_acc_reg;

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // Next-state logic and status outputs
  always_comb begin
    state_next = state_reg;
    busy_o     = 1'b0;
    done_o     = 1'b0;
    div_zero_o = 1'b0;
    case (state_reg)
      IDLE: begin
        if (accept) state_next = div_zero_start ? DONE : CALC;
      end
      CALC: begin
        busy_o = 1'b1;
        if (cnt_reg == CNT_W'(1)) state_next = FIX;
      end
      FIX: begin
        busy_o     = 1'b1;
        state_next = DONE;
      end
      DONE: begin
        done_o     = 1'b1;
        div_zero_o = dz_reg;
        if (accept) state_next = div_zero_start ? DONE : CALC;
        else        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Operand latch on acceptance, then one algorithm step per CALC cycle
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_reg     <= '0;
      a_reg       <= '0;
      hi_acc_reg  <= '0;
      lo_acc_reg  <= '0;
      op_div_reg  <= 1'b0;
      neg_res_reg <= 1'b0;
      neg_rem_reg <= 1'b0;
      dz_reg      <= 1'b0;
    end else if (accept) begin
      cnt_reg     <= CNT_W'(DATA_W);
      a_reg       <= op_i[1] ? mag2 : mag1;
      hi_acc_reg  <= '0;
      lo_acc_reg  <= op_i[1] ? mag1 : mag2;
      op_div_reg  <= op_i[1];
      neg_res_reg <= s1_neg ^ s2_neg;
      neg_rem_reg <= s1_neg;
      dz_reg      <= div_zero_start;
    end else if (state_reg == CALC) begin
      cnt_reg <= cnt_reg - CNT_W'(1);
      if (op_div_reg) begin
        if (!div_diff[DATA_W]) begin
          hi_acc_reg <= div_diff[DATA_W-1:0];
          lo_acc_reg <= {lo_acc_reg[DATA_W-2:0], 1'b1};
        end else begin
          hi_acc_reg <= div_shift[DATA_W-1:0];
          lo_acc_reg <= {lo_acc_reg[DATA_W-2:0], 1'b0};
        end
      end else begin
        hi_acc_reg <= mul_sum[DATA_W:1];
        lo_acc_reg <= {mul_sum[0], lo_acc_reg[DATA_W-1:1]};
      end
    end
  end

  // HI/LO: result commit in FIX, MTHI/MTLO only when no operation is in flight
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hi_reg <= '0;
      lo_reg <= '0;
    end else if (state_reg == FIX) begin
      if (op_div_reg) begin
        hi_reg <= rem_fix;
        lo_reg <= quo_fix;
      end else begin
        hi_reg <= prod_fix[2*DATA_W-1:DATA_W];
        lo_reg <= prod_fix[DATA_W-1:0];
      end
    end else if (idle_or_done) begin
      if (hi_we_i) hi_reg <= wdata_i;
      if (lo_we_i) lo_reg <= wdata_i;
    end
  end

  assign hi_o = hi_reg;
  assign lo_o = lo_reg;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: stimulus pushes expected HI/LO/div-zero
// into a scoreboard queue; a monitor pops and compares on every done_o.
module tb_mul_div_unit;

  localparam int W = 32;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          start_i;
  logic [1:0]    op_i;
  logic [W-1:0]  src1_i, src2_i;
  logic          hi_we_i, lo_we_i;
  logic [W-1:0]  wdata_i;
  logic          busy_o, done_o, div_zero_o;
  logic [W-1:0]  hi_o, lo_o;

  typedef struct packed {
    logic [7:0]   id;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  localparam logic [1:0] OP_MULT = 2'b00, OP_MULTU = 2'b01, OP_DIV = 2'b10, OP_DIVU = 2'b11;

  mul_div_unit #(.DATA_W(W), .SIGN_EN(1'b1)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .start_i    (start_i),
    .op_i       (op_i),
    .src1_i     (src1_i),
    .src2_i     (src2_i),
    .hi_we_i    (hi_we_i),
    .lo_we_i    (lo_we_i),
    .wdata_i    (wdata_i),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .div_zero_o (div_zero_o),
    .hi_o       (hi_o),
    .lo_o       (lo_o)
  );

  always #5 clk_i = ~clk_i;

  // Monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge clk_i) begin
    exp_t e;
    if (!rst_i && done_o) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: hi=%h lo=%h dz=%b with empty scoreboard", hi_o, lo_o, div_zero_o);
      end else begin
        e = sb_q.pop_front();
        if (hi_o !== e.hi || lo_o !== e.lo || div_zero_o !== e.dz) begin
          errors++;
          $display("FAIL txn_%0d: got hi=%h lo=%h dz=%b, expected hi=%h lo=%h dz=%b",
                   e.id, hi_o, lo_o, div_zero_o, e.hi, e.lo, e.dz);
        end else begin
          $display("txn %0d ok: hi=%h lo=%h dz=%b", e.id, hi_o, lo_o, div_zero_o);
        end
      end
    end
  end

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  // Called at a negedge; returns at the negedge of the DONE cycle so the
  // next call starts back-to-back. Optionally injects start/MTHI in CALC.
  task automatic run_op(input logic [7:0] id, input logic [1:0] op,
                        input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] ehi, input logic [W-1:0] elo,
                        input logic edz, input int elat, input bit inject);
    exp_t e;
    int   lat;
    bit   busy_bad;
    e.id = id; e.hi = ehi; e.lo = elo; e.dz = edz;
    sb_q.push_back(e);
    op_i = op; src1_i = a; src2_i = b; start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0; src1_i = '0; src2_i = '0;
    lat = 0;
    busy_bad = 1'b0;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk_i);
      if (done_o) begin
        lat = c;
        break;
      end
      if (!busy_o) busy_bad = 1'b1;
      if (inject && c == 5) begin
        start_i = 1'b1; op_i = OP_DIVU; src1_i = 32'd99; src2_i = 32'd3;
        hi_we_i = 1'b1; wdata_i = 32'h0000ABCD;
      end
      if (inject && c == 6) begin
        start_i = 1'b0; hi_we_i = 1'b0; src1_i = '0; src2_i = '0;
      end
    end
    check($sformatf("latency_%0d", id), W'(lat), W'(elat));
    check($sformatf("busy_%0d", id), {31'd0, busy_bad | busy_o}, 32'd0);
  endtask

  task automatic mt(input logic hw, input logic lw, input logic [W-1:0] d);
    hi_we_i = hw; lo_we_i = lw; wdata_i = d;
    @(posedge clk_i); #1;
    hi_we_i = 1'b0; lo_we_i = 1'b0; wdata_i = '0;
    @(negedge clk_i);
  endtask

  initial begin
    rst_i = 1'b1; start_i = 1'b0; op_i = 2'b00; src1_i = '0; src2_i = '0;
    hi_we_i = 1'b0; lo_we_i = 1'b0; wdata_i = '0;
    @(negedge clk_i);
    check("reset_hi", hi_o, 32'd0);
    check("reset_lo", lo_o, 32'd0);
    check("reset_busy", {31'd0, busy_o}, 32'd0);
    check("reset_done", {31'd0, done_o}, 32'd0);
    check("reset_dz", {31'd0, div_zero_o}, 32'd0);
    rst_i = 1'b0;
    idle(1);

    run_op(1, OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 34, 1'b0);
    idle(2);
    run_op(2, OP_MULT, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0, 34, 1'b0);
    run_op(3, OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 34, 1'b0);
    idle(1);
    run_op(4, OP_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 34, 1'b0);
    idle(1);
    run_op(5, OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 1'b0, 34, 1'b0);
    idle(1);
    run_op(6, OP_MULT, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'd0, 32'd6, 1'b0, 34, 1'b0);
    idle(1);
    run_op(7, OP_DIV, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD, 1'b0, 34, 1'b0);
    idle(1);

    mt(1'b1, 1'b0, 32'h11);
    mt(1'b0, 1'b1, 32'h22);
    check("mthi", hi_o, 32'h11);
    check("mtlo", lo_o, 32'h22);
    run_op(8, OP_DIVU, 32'd7, 32'd0, 32'h11, 32'h22, 1'b1, 1, 1'b0);
    idle(1);

    // Reset in cycle 10 of a multiply: outputs clear without waiting for a clock edge
    op_i = OP_MULTU; src1_i = 32'hFFFFFFFF; src2_i = 32'hFFFFFFFF; start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    repeat (8) @(posedge clk_i);
    #1;
    check("busy_before_reset", {31'd0, busy_o}, 32'd1);
    rst_i = 1'b1;
    #1;
    check("async_busy", {31'd0, busy_o}, 32'd0);
    check("async_hi", hi_o, 32'd0);
    check("async_lo", lo_o, 32'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    idle(1);
    run_op(9, OP_MULTU, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0, 34, 1'b0);
    idle(1);

    run_op(10, OP_MULTU, 32'h1234, 32'h10, 32'd0, 32'h00012340, 1'b0, 34, 1'b1);
    idle(2);
    mt(1'b1, 1'b0, 32'h0000ABCD);
    check("idle_mthi", hi_o, 32'h0000ABCD);
    check("idle_lo_kept", lo_o, 32'h00012340);

    idle(3);
    check("scoreboard_empty", sb_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule
